bit4_alu: RTL and testbench
===========================

Name: bit4_alu

Overview:
- Registered 4-bit ALU.
- Takes two operands and a 4-bit opcode; produces a 5-bit result whose MSB carries the carry/borrow or shifted-out data.
- Leaf datapath block used wherever small-width arithmetic/logic is needed.
- Output is registered: one-cycle latency, asynchronous active-low reset.

Parameters:
- W, 4, operand width; result width is W+1. Only W=4 is required to be verified.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  W  operand A, unsigned
- b  input  W  operand B, unsigned; also the shift amount for shift ops
- sel  input  4  opcode
- y  output  W+1  registered result

Behaviour:
- rst_n low clears y to 0 immediately, independent of clk, and holds it at 0 while low.
- Release of rst_n is sampled at clk; the first rising edge with rst_n high loads a result.
- Each rising edge with rst_n high loads y with f(a, b, sel) sampled at that edge.
  - Latency is exactly 1 cycle; y holds between edges.
  - No enable or handshake; every cycle is a new operation.
- Opcodes, with A and B zero-extended to W+1 bits:
  - 0000 ADD: y = A + B; y[W] is carry out.
  - 0001 SUB: y = A - B, modulo 2^(W+1); y[W]=1 means borrow (a<b).
  - 0010 AND: y = {0, a&b}
  - 0011 OR: y = {0, a|b}
  - 0100 XOR: y = {0, a^b}
  - 0101 XNOR: y = {0, ~(a^b)}
  - 0110 NOT: y = {0, ~a}; b is ignored.
  - 0111 SHL: y = (A << b[1:0]) truncated to W+1 bits; zeros fill in; bits beyond y[W] are lost.
  - 1000 SHR: y = {0, a >> b[1:0]}, logical shift with zero fill.
  - 1001 INC: y = A + 1; carry in y[W].
  - 1010 DEC: y = A - 1; a=0 gives 11111.
  - 1011 NAND: y = {0, ~(a&b)}
  - 1100 NOR: y = {0, ~(a|b)}
  - 1101 PASSA: y = {0, a}
  - 1110 PASSB: y = {0, b}
  - 1111 ZERO: y = 0
- Boundaries:
  - ADD 1111+1111 gives 11110.
  - SUB 0000-0001 gives 11111.
  - Shift by 0 passes a through.
  - Only b[1:0] is used as the shift amount.
- X/unknown on sel must not latch; the default branch produces 0.

Optional Feature:
- Macro: BIT4_ALU_FLAGS_EN.
- When defined, two extra outputs exist, registered in the same edge as y and reset to 0:
  - zero (1 bit): 1 when y[W-1:0] == 0 for the new result.
  - ovf (1 bit): signed two's-complement overflow for ADD/SUB/INC/DEC on W-bit operands; 0 for all other ops.
- When undefined, these ports and their registers do not exist; y behaviour is identical in both cases.

Decomposition:
- Package bit4_alu_pkg holds:
  - opcode localparams OP_ADD … OP_ZERO (4 bits);
  - the default width constant ALU_W=4.
- One combinational sub-module, bit4_alu_core, computes the W+1-bit result (and flags) from a, b, sel.
- Top bit4_alu contains only the output registers and reset.

Test Plan:
- Reset: rst_n=0 mid-cycle with a=0011, b=1001, sel=0000 -> y=00000 immediately, without a clock edge. Release rst_n, then one edge -> y=01100.
- Arithmetic, each checked one edge after applying inputs:
  - ADD 0011+1001 -> 01100
  - SUB 1010-1001 -> 00001
  - SUB 0010-0110 -> 11100
  - ADD 1111+1111 -> 11110
  - INC 1111 -> 10000
  - DEC 0000 -> 11111
- Logic:
  - AND 1111,1010 -> 01010
  - OR 1001,0110 -> 01111
  - XOR 0010,0110 -> 00100
  - XNOR 1001,1010 -> 01100
  - NOT a=1010 -> 00101
- Shifts:
  - SHL a=1111, b=0001 -> 11110
  - SHL a=1111, b=0011 -> 11000
  - SHR a=1010, b=0011 -> 00001
  - SHR a=1010, b=0100 (amount 0) -> 01010
- Back-to-back: change sel every cycle through all 16 opcodes -> each y matches the previous cycle's inputs, with no bubble. Pass/zero ops return a, b and 0.
- Flags (BIT4_ALU_FLAGS_EN):
  - ADD 0111+0001 -> ovf=1, zero=0
  - SUB 0101-0101 -> zero=1, ovf=0
  - AND 1010,0101 -> zero=1

Source files
------------

// File: rtl/bit4_alu_pkg.sv
// Shared opcode encodings and width constant for the registered 4-bit ALU.
// Optional flag outputs are enabled with the BIT4_ALU_FLAGS_EN macro.
package bit4_alu_pkg;

  localparam int unsigned ALU_W = 4;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_XNOR  = 4'b0101,
    OP_NOT   = 4'b0110,
    OP_SHL   = 4'b0111,
    OP_SHR   = 4'b1000,
    OP_INC   = 4'b1001,
    OP_DEC   = 4'b1010,
    OP_NAND  = 4'b1011,
    OP_NOR   = 4'b1100,
    OP_PASSA = 4'b1101,
    OP_PASSB = 4'b1110,
    OP_ZERO  = 4'b1111
  } alu_op_e;

  // Two's-complement overflow of r = x + y, given the sign bits of x, y and r.
  function automatic logic signed_ovf(input logic x_s, input logic y_s, input logic r_s);
    return (x_s == y_s) && (r_s != x_s);
  endfunction

endpackage

// File: rtl/bit4_alu_core.sv
// Combinational ALU datapath: W+1-bit result (and optional flags) from a, b, sel.
// Flag outputs exist only when BIT4_ALU_FLAGS_EN is defined.
module bit4_alu_core
  import bit4_alu_pkg::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   sel,
  output logic [W:0]   result
`ifdef BIT4_ALU_FLAGS_EN
  ,
  output logic         zero,
  output logic         ovf
`endif
);

  localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

  logic [W:0] ax;
  logic [W:0] bx;
  logic [W:0] res;
  logic       ovf_c;

  assign ax = {1'b0, a};
  assign bx = {1'b0, b};

  // Unknown or unlisted opcodes fall to the default and yield zero.
  always_comb begin
    res   = '0;
    ovf_c = 1'b0;
    case (sel)
      OP_ADD: begin
        res   = ax + bx;
        ovf_c = signed_ovf(a[W-1], b[W-1], res[W-1]);
      end
      OP_SUB: begin
        res   = ax - bx;
        ovf_c = signed_ovf(a[W-1], ~b[W-1], res[W-1]);
      end
      OP_AND:   res = {1'b0, a & b};
      OP_OR:    res = {1'b0, a | b};
      OP_XOR:   res = {1'b0, a ^ b};
      OP_XNOR:  res = {1'b0, ~(a ^ b)};
      OP_NOT:   res = {1'b0, ~a};
      OP_SHL:   res = ax << b[1:0];
      OP_SHR:   res = {1'b0, a >> b[1:0]};
      OP_INC: begin
        res   = ax + ONE;
        ovf_c = signed_ovf(a[W-1], 1'b0, res[W-1]);
      end
      OP_DEC: begin
        res   = ax - ONE;
        ovf_c = signed_ovf(a[W-1], 1'b1, res[W-1]);
      end
      OP_NAND:  res = {1'b0, ~(a & b)};
      OP_NOR:   res = {1'b0, ~(a | b)};
      OP_PASSA: res = ax;
      OP_PASSB: res = bx;
      OP_ZERO:  res = '0;
      default: begin
        res   = '0;
        ovf_c = 1'b0;
      end
    endcase
  end

  assign result = res;

`ifdef BIT4_ALU_FLAGS_EN
  assign zero = (res[W-1:0] == '0);
  assign ovf  = ovf_c;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_c;
`endif

endmodule

// File: rtl/bit4_alu.sv
// Registered 4-bit ALU: one-cycle latency, asynchronous active-low reset.
// Define BIT4_ALU_FLAGS_EN to add registered zero/ovf flag outputs.
module bit4_alu
  import bit4_alu_pkg::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   sel,
  output logic [W:0]   y
`ifdef BIT4_ALU_FLAGS_EN
  ,
  output logic         zero,
  output logic         ovf
`endif
);

  logic [W:0] y_d;
  logic [W:0] y_q;
  logic [W:0] core_result;

`ifdef BIT4_ALU_FLAGS_EN
  logic core_zero;
  logic core_ovf;
  logic zero_d, zero_q;
  logic ovf_d, ovf_q;
`endif

  bit4_alu_core #(
    .W (W)
  ) u_core (
    .a      (a),
    .b      (b),
    .sel    (sel),
    .result (core_result)
`ifdef BIT4_ALU_FLAGS_EN
    ,
    .zero   (core_zero),
    .ovf    (core_ovf)
`endif
  );

  always_comb begin
    y_d = core_result;
`ifdef BIT4_ALU_FLAGS_EN
    zero_d = core_zero;
    ovf_d  = core_ovf;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
`ifdef BIT4_ALU_FLAGS_EN
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      y_q <= y_d;
`ifdef BIT4_ALU_FLAGS_EN
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign y = y_q;
`ifdef BIT4_ALU_FLAGS_EN
  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_bit4_alu.sv
// Self-checking bench for bit4_alu: directed cases plus random ops vs. an integer model.
// Flag checks are compiled in when BIT4_ALU_FLAGS_EN is defined.
module tb_bit4_alu;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] sel;
  logic [4:0] y;
`ifdef BIT4_ALU_FLAGS_EN
  logic       zero;
  logic       ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bit4_alu #(
    .W (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .sel   (sel),
    .y     (y)
`ifdef BIT4_ALU_FLAGS_EN
    ,
    .zero  (zero),
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on the opcode's mathematical meaning.
  function automatic int ref_y(input int ai, input int bi, input int op);
    int s;
    s = bi % 4;
    case (op)
      0:  return (ai + bi) % 32;
      1:  return (ai - bi + 32) % 32;
      2:  return ai & bi;
      3:  return ai | bi;
      4:  return ai ^ bi;
      5:  return 15 - (ai ^ bi);
      6:  return 15 - ai;
      7:  return (ai * (2 ** s)) % 32;
      8:  return ai / (2 ** s);
      9:  return (ai + 1) % 32;
      10: return (ai + 31) % 32;
      11: return 15 - (ai & bi);
      12: return 15 - (ai | bi);
      13: return ai;
      14: return bi;
      default: return 0;
    endcase
  endfunction

  function automatic int sval(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  function automatic int ref_ovf(input int ai, input int bi, input int op);
    int r;
    case (op)
      0:  r = sval(ai) + sval(bi);
      1:  r = sval(ai) - sval(bi);
      9:  r = sval(ai) + 1;
      10: r = sval(ai) - 1;
      default: return 0;
    endcase
    return (r > 7 || r < -8) ? 1 : 0;
  endfunction

  task automatic step(input string tag, input logic [3:0] ta, input logic [3:0] tbv,
                      input logic [3:0] op, input logic [4:0] exp);
    @(negedge clk);
    a   = ta;
    b   = tbv;
    sel = op;
    @(posedge clk);
    #1;
    check(tag, {3'b0, y}, {3'b0, exp});
`ifdef BIT4_ALU_FLAGS_EN
    check({tag, "_zero"}, {7'b0, zero}, {7'b0, exp[3:0] == 4'b0});
    check({tag, "_ovf"}, {7'b0, ovf}, 8'(ref_ovf(int'(ta), int'(tbv), int'(op))));
`endif
  endtask

  initial begin
    logic [3:0] ra, rb, rop;
    rst_n = 1'b0;
    a = '0; b = '0; sel = '0;
    #1;
    check("reset_initial", {3'b0, y}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Load a nonzero value, then assert reset mid-cycle and observe async clear.
    step("passa_pre", 4'b1111, 4'b0000, 4'b1101, 5'b01111);
    #2;
    a = 4'b0011; b = 4'b1001; sel = 4'b0000;
    rst_n = 1'b0;
    #1;
    check("reset_async", {3'b0, y}, 8'h00);
    @(posedge clk);
    #1;
    check("reset_hold", {3'b0, y}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", {3'b0, y}, 8'b0000_1100);

    step("add",      4'b0011, 4'b1001, 4'b0000, 5'b01100);
    step("sub_pos",  4'b1010, 4'b1001, 4'b0001, 5'b00001);
    step("sub_neg",  4'b0010, 4'b0110, 4'b0001, 5'b11100);
    step("sub_bnd",  4'b0000, 4'b0001, 4'b0001, 5'b11111);
    step("add_max",  4'b1111, 4'b1111, 4'b0000, 5'b11110);
    step("inc_max",  4'b1111, 4'b0000, 4'b1001, 5'b10000);
    step("dec_zero", 4'b0000, 4'b0000, 4'b1010, 5'b11111);
    step("and",      4'b1111, 4'b1010, 4'b0010, 5'b01010);
    step("or",       4'b1001, 4'b0110, 4'b0011, 5'b01111);
    step("xor",      4'b0010, 4'b0110, 4'b0100, 5'b00100);
    step("xnor",     4'b1001, 4'b1010, 4'b0101, 5'b01100);
    step("not",      4'b1010, 4'b0110, 4'b0110, 5'b00101);
    step("shl_1",    4'b1111, 4'b0001, 4'b0111, 5'b11110);
    step("shl_3",    4'b1111, 4'b0011, 4'b0111, 5'b11000);
    step("shr_3",    4'b1010, 4'b0011, 4'b1000, 5'b00001);
    step("shr_0",    4'b1010, 4'b0100, 4'b1000, 5'b01010);
    step("shl_0",    4'b0110, 4'b1100, 4'b0111, 5'b00110);

`ifdef BIT4_ALU_FLAGS_EN
    step("f_add_ovf", 4'b0111, 4'b0001, 4'b0000, 5'b01000);
    check("f_add_ovf_const", {6'b0, ovf, zero}, 8'b0000_0010);
    step("f_sub_zero", 4'b0101, 4'b0101, 4'b0001, 5'b00000);
    check("f_sub_zero_const", {6'b0, ovf, zero}, 8'b0000_0001);
    step("f_and_zero", 4'b1010, 4'b0101, 4'b0010, 5'b00000);
    check("f_and_zero_const", {7'b0, zero}, 8'b0000_0001);
`endif

    // Back-to-back sweep through every opcode, no idle cycles.
    for (int i = 0; i < 16; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rop = 4'(i);
      step($sformatf("sweep_op%0d", i), ra, rb, rop,
           5'(ref_y(int'(ra), int'(rb), int'(rop))));
    end

    for (int i = 0; i < 300; i++) begin
      ra  = 4'($urandom);
      rb  = 4'($urandom);
      rop = 4'($urandom);
      step($sformatf("rand_%0d_op%0d", i, rop), ra, rb, rop,
           5'(ref_y(int'(ra), int'(rb), int'(rop))));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
